// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter and receiver: FSM states,
// frame geometry, line levels and the baud divisor calculation.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam int   DATA_BITS  = 8;
    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

    // Truncating division; every bit on the line lasts this many clocks.
    function automatic int baud_div(input int fclk, input int fbaud);
        return fclk / fbaud;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Loadable bit-width down-counter: load_i restarts a BAUD_DIV-cycle period,
// zero_o is high in the last cycle of that period.
module uart_baud_cnt #(
    parameter int BAUD_DIV = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    output logic zero_o
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] ONE    = CW'(1);

    if (BAUD_DIV < 2) begin : g_bad_div
        $error("uart_baud_cnt: BAUD_DIV must be at least 2");
    end

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          zero_q;

    // Next count: reload on request, otherwise count down and hold at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = RELOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register and registered zero flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            zero_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            zero_q <= (cnt_d == '0);
        end
    end

    assign zero_o = zero_q;

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: accepts a byte in IDLE and serialises start bit,
// eight data bits LSB first and stop bit, each BAUD_DIV clocks long.
module uart_tx
    import uart_pkg::*;
#(
    parameter int fclk  = 50000000,
    parameter int fbaud = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx
);

    localparam int BAUD_DIV = baud_div(fclk, fbaud);
    localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

    if (BAUD_DIV < 2) begin : g_bad_div
        $error("uart_tx: fclk/fbaud must be at least 2");
    end

    uart_state_e state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic        tx_q, tx_d;
    logic        done_q, done_d;
    logic        load_s;
    logic        zero_s;

    uart_baud_cnt #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (load_s),
        .zero_o (zero_s)
    );

    // Frame sequencing: every bit transition reloads the width counter.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        tx_d     = tx_q;
        done_d   = 1'b0;
        load_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_d = LINE_IDLE;
                if (tx_start) begin
                    shift_d = tx_data;
                    load_s  = 1'b1;
                    state_d = ST_START;
                    tx_d    = LINE_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                tx_d = LINE_START;
                if (zero_s) begin
                    state_d  = ST_DATA;
                    load_s   = 1'b1;
                    bitcnt_d = 3'd0;
                    tx_d     = shift_q[0];
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                tx_d = shift_q[0];
                if (zero_s) begin
                    load_s = 1'b1;
                    if (bitcnt_q == BIT_LAST) begin
                        state_d = ST_STOP;
                        tx_d    = LINE_IDLE;
                    end else begin
                        // tx must show the new LSB in the same edge as the shift.
                        shift_d  = {1'b0, shift_q[7:1]};
                        bitcnt_d = bitcnt_q + 3'd1;
                        tx_d     = shift_q[1];
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_STOP: begin
                tx_d = LINE_IDLE;
                if (zero_s) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = LINE_IDLE;
            end
        endcase
    end

    // State, data path and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            shift_q  <= 8'h00;
            bitcnt_q <= 3'd0;
            tx_q     <= LINE_IDLE;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
            tx_q     <= tx_d;
            done_q   <= done_d;
        end
    end

    assign tx_ready = (state_q == ST_IDLE);
    assign tx_busy  = (state_q != ST_IDLE);
    assign tx_done  = done_q;
    assign tx       = tx_q;

endmodule
